// File: rtl/nn_node.sv
// Single-neuron MAC node: serial signed Q8.8 multiply-accumulate into a saturating
// Q24.16 accumulator, then a registered 3-bit ReLU/saturate activation.
module nn_node #(
    parameter int N_IN = 64,
    parameter int DW   = 16,
    parameter int AW   = 40
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic                     reset_acc,
    input  logic [$clog2(N_IN):0]    cnt_val,
    input  logic signed [DW-1:0]     coef    [N_IN-1:0],
    input  logic signed [DW-1:0]     data_in [N_IN-1:0],
    output logic [2:0]               node_out
);
    localparam int IW = $clog2(N_IN);
    localparam int FB = DW;  // Q8.8 x Q8.8 leaves DW fractional bits
    localparam logic [IW:0]          N_MAX   = (IW+1)'(N_IN);
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_UPDATE} state_t;

    state_t                r_state;
    logic signed [AW-1:0]  r_acc;
    logic [IW-1:0]         r_idx;
    logic [IW-1:0]         r_last;

    logic                  w_zero;
    logic [IW-1:0]         w_last;
    logic signed [2*DW-1:0] w_prod;
    logic signed [AW:0]    w_sum;
    logic signed [AW-1:0]  w_acc_nxt;
    logic [AW-FB-1:0]      w_int;
    logic [2:0]            w_act;

    // Counts above N_IN clamp to a full pass; only the last index is kept.
    assign w_zero = (cnt_val == '0);
    assign w_last = (cnt_val >= N_MAX) ? {IW{1'b1}} : (cnt_val[IW-1:0] - IW'(1));

    assign w_prod = (2*DW)'(data_in[r_idx]) * (2*DW)'(coef[r_idx]);
    assign w_sum  = (AW+1)'(r_acc) + (AW+1)'(w_prod);

    // One guard bit catches overflow; clamp toward the sign of the true sum.
    always_comb begin
        w_acc_nxt = w_sum[AW-1:0];
        if (w_sum[AW] != w_sum[AW-1])
            w_acc_nxt = w_sum[AW] ? ACC_MIN : ACC_MAX;
    end

    assign w_int = r_acc[AW-1:FB];

    always_comb begin
        w_act = 3'd0;
        if (!w_int[AW-FB-1] && (w_int != '0)) begin
            if (w_int >= (AW-FB)'(7))
                w_act = 3'd7;
            else
                w_act = w_int[2:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_idx    <= '0;
            r_last   <= '0;
            node_out <= 3'd0;
        end else if (reset_acc) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_last  <= w_last;
                        r_state <= w_zero ? S_UPDATE : S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    r_idx <= r_idx + IW'(1);
                    if (r_idx == r_last)
                        r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    node_out <= w_act;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_node.sv
// Scoreboarded bench for nn_node: stimulus pushes expected activations with their due
// cycle; a negedge monitor compares on the due cycle and checks node_out holds otherwise.
module tb_nn_node;
    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic              reset_acc;
    logic [6:0]        cnt_val;
    logic signed [15:0] coef    [63:0];
    logic signed [15:0] data_in [63:0];
    logic [2:0]        node_out;

    nn_node #(.N_IN(64), .DW(16), .AW(40)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .reset_acc (reset_acc),
        .cnt_val   (cnt_val),
        .coef      (coef),
        .data_in   (data_in),
        .node_out  (node_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [2:0] val;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] exp_last = 3'd0;
    int         n_checks = 0;
    int         n_pass   = 0;
    longint     m_acc    = 0;

    localparam longint AMAX = (longint'(1) <<< 39) - 1;
    localparam longint AMIN = -(longint'(1) <<< 39);

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: node_out=%0d expected=%0d", name, cyc, act, exp);
    endtask

    // Reference: integer part of the Q24.16 value, clamped to 0..7.
    function automatic logic [2:0] act_of(input longint a);
        longint i;
        i = a >>> 16;
        if (i <= 0) return 3'd0;
        if (i >= 7) return 3'd7;
        return 3'(i);
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("late", node_out, sb[0].val);
            exp_last = sb[0].val;
            void'(sb.pop_front());
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            chk("result", node_out, sb[0].val);
            exp_last = sb[0].val;
            void'(sb.pop_front());
        end else begin
            chk("hold", node_out, exp_last);
        end
    end

    task automatic fill(input logic [15:0] d, input logic [15:0] c);
        for (int i = 0; i < 64; i++) begin
            data_in[i] = d;
            coef[i]    = c;
        end
    endtask

    task automatic do_pass(input int cnt, input bit glitch);
        int n;
        longint s;
        @(negedge clk); #1;
        cnt_val = 7'(cnt);
        start   = 1'b1;
        n = (cnt > 64) ? 64 : cnt;
        for (int i = 0; i < n; i++) begin
            s = m_acc + longint'(data_in[i]) * longint'(coef[i]);
            m_acc = (s > AMAX) ? AMAX : (s < AMIN) ? AMIN : s;
        end
        sb.push_back('{cyc + n + 2, act_of(m_acc)});
        @(negedge clk); #1;
        start = 1'b0;
        if (glitch && n >= 3) begin
            @(negedge clk); #1;
            start = 1'b1;
            @(negedge clk); #1;
            start = 1'b0;
            repeat (n - 1) @(negedge clk);
        end else begin
            repeat (n + 1) @(negedge clk);
        end
    endtask

    task automatic clr_acc(input bit with_start);
        @(negedge clk); #1;
        reset_acc = 1'b1;
        start     = with_start;
        cnt_val   = 7'd1;
        m_acc     = 0;
        sb.delete();
        @(negedge clk); #1;
        reset_acc = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; reset_acc = 1'b0; cnt_val = 7'd0;
        for (int i = 0; i < 64; i++) begin
            data_in[i] = 16'($urandom);
            coef[i]    = 16'($urandom);
        end
        repeat (2) @(posedge clk);
        #1 chk("reset", node_out, 3'd0);
        @(negedge clk); #1 n_rst = 1'b1;
        repeat (5) @(negedge clk);

        fill(16'h0000, 16'h0000);
        data_in[0] = 16'h0100; coef[0] = 16'h0300;
        do_pass(1, 1'b0);                          // 3
        fill(16'h0200, 16'h0100);
        do_pass(4, 1'b0);                          // 11.0 -> 7
        clr_acc(1'b0);
        fill(16'h0180, 16'h0100);
        do_pass(2, 1'b0);                          // 3.0 -> 3
        clr_acc(1'b0);
        fill(16'h0100, 16'hFE00);
        do_pass(1, 1'b0);                          // -2 -> 0
        clr_acc(1'b1);
        fill(16'h0100, 16'h0300);
        do_pass(1, 1'b0);                          // 3
        do_pass(1, 1'b0);                          // 6
        do_pass(1, 1'b0);                          // 7
        do_pass(0, 1'b0);                          // unchanged

        // Abort a full pass two cycles in; node_out must hold.
        fill(16'h0100, 16'h0100);
        @(negedge clk); #1 cnt_val = 7'd64; start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        clr_acc(1'b0);
        repeat (3) @(negedge clk);
        do_pass(1, 1'b0);                          // 1

        // Async reset mid-pass clears node_out at once.
        fill(16'h0200, 16'h0200);
        @(negedge clk); #1 cnt_val = 7'd20; start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #1 n_rst = 1'b0;
        m_acc = 0; sb.delete(); exp_last = 3'd0;
        #1 chk("async_rst", node_out, 3'd0);
        repeat (2) @(negedge clk);
        #1 n_rst = 1'b1;

        // Positive saturation must pin, not wrap: +max then exactly -2^39 lands at -1.
        clr_acc(1'b0);
        fill(16'h8000, 16'h8000);
        repeat (9) do_pass(64, 1'b0);
        fill(16'h4000, 16'hC000);
        repeat (32) do_pass(64, 1'b0);
        fill(16'h0380, 16'h0100);
        do_pass(1, 1'b0);
        // Negative saturation likewise.
        clr_acc(1'b0);
        fill(16'h8000, 16'h7FFF);
        repeat (9) do_pass(64, 1'b0);
        fill(16'h4000, 16'h4000);
        repeat (32) do_pass(64, 1'b0);
        fill(16'h0380, 16'h0100);
        do_pass(1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 64; i++) begin
                if (wide) begin
                    data_in[i] = 16'($urandom);
                    coef[i]    = 16'($urandom);
                end else begin
                    data_in[i] = 16'($signed($urandom_range(0, 1536)) - 768);
                    coef[i]    = 16'($signed($urandom_range(0, 512)) - 256);
                end
            end
            if ($urandom_range(0, 4) == 0) clr_acc(1'($urandom_range(0, 1)));
            do_pass(($urandom_range(0, 3) == 0) ? int'($urandom_range(65, 127))
                                                : int'($urandom_range(0, 64)),
                    1'($urandom_range(0, 1)));
        end

        for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
